// File: rtl/cpu_irq_ctrl.sv
// Fabric IRQ synchronizer, pending/overflow latch and prioritized
// req/ack front end for the CPU interrupt input.
module cpu_irq_ctrl #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               UserCLK,
    input  logic               RESETn,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               CONFIGURED,
    input  logic [NUM_IRQ-1:0] edge_mode,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NUM_IRQ-1:0] s1;
    logic [NUM_IRQ-1:0] s2;
    logic [NUM_IRQ-1:0] s3;
    logic [NUM_IRQ-1:0] evt;
    logic [NUM_IRQ-1:0] ack_vec;
    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] pend_nxt;
    logic [NUM_IRQ-1:0] ovf_nxt;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    id_nxt;
    logic               win_any;
    logic               ack_go;

    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= IRQ;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        evt     = s2 & ~s3;
        ack_go  = (state == REQ) && irq_ack;
        ack_vec = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (ack_go && irq_id == ID_W'(i)) ack_vec[i] = 1'b1;
        end
        elig    = pending & irq_mask;
        win_any = |elig;
        win_id  = '0;
        // descending scan so the lowest eligible index wins
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) win_id = ID_W'(i);
        end
    end

    always_comb begin
        pend_nxt = '0;
        ovf_nxt  = '0;
        if (CONFIGURED) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (edge_mode[i]) begin
                    pend_nxt[i] = evt[i] | (pending[i] & ~ack_vec[i]);
                    // an edge racing its own ACK re-arms pending only
                    if (ack_vec[i] && evt[i])
                        ovf_nxt[i] = overflow[i];
                    else if (ack_vec[i])
                        ovf_nxt[i] = 1'b0;
                    else
                        ovf_nxt[i] = overflow[i] | (evt[i] & pending[i]);
                end else begin
                    pend_nxt[i] = s2[i];
                    ovf_nxt[i]  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = irq_id;
        if (!CONFIGURED) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_any) begin
                        state_nxt = REQ;
                        id_nxt    = win_id;
                    end
                end
                REQ: begin
                    if (irq_ack) state_nxt = GAP;
                end
                GAP:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= IDLE;
            irq_req  <= 1'b0;
            irq_id   <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            state    <= state_nxt;
            irq_req  <= (state_nxt == REQ);
            irq_id   <= id_nxt;
            pending  <= pend_nxt;
            overflow <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Directed bench for cpu_irq_ctrl: latency, priority, level re-request,
// overflow, CONFIGURED gating, masking and async reset.
module tb_cpu_irq_ctrl;

    logic       UserCLK;
    logic       RESETn;
    logic [3:0] IRQ;
    logic       CONFIGURED;
    logic [3:0] edge_mode;
    logic [3:0] irq_mask;
    logic       irq_req;
    logic [1:0] irq_id;
    logic       irq_ack;
    logic [3:0] pending;
    logic [3:0] overflow;

    int n_chk  = 0;
    int n_pass = 0;

    cpu_irq_ctrl #(.NUM_IRQ(4)) dut (
        .UserCLK   (UserCLK),
        .RESETn    (RESETn),
        .IRQ       (IRQ),
        .CONFIGURED(CONFIGURED),
        .edge_mode (edge_mode),
        .irq_mask  (irq_mask),
        .irq_req   (irq_req),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge UserCLK);
            #1;
        end
    endtask

    initial begin
        RESETn = 1'b0;
        IRQ = 4'h0;
        CONFIGURED = 1'b1;
        edge_mode = 4'hF;
        irq_mask = 4'hF;
        irq_ack = 1'b0;
        tick(2);
        chk("rst_req", irq_req, 0);
        chk("rst_id", irq_id, 0);
        chk("rst_pend", pending, 0);
        chk("rst_ovf", overflow, 0);
        RESETn = 1'b1;

        // single edge pulse on line 2
        IRQ = 4'b0100;
        tick(1);
        chk("t1_req_n", irq_req, 0);
        tick(2);
        chk("t1_pend", pending, 4'b0100);
        chk("t1_req_n2", irq_req, 0);
        IRQ = 4'h0;
        tick(1);
        chk("t1_req", irq_req, 1);
        chk("t1_id", irq_id, 2);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("t1_ack_req", irq_req, 0);
        chk("t1_ack_pend", pending, 0);
        tick(1);
        chk("t1_gap", irq_req, 0);
        tick(1);
        chk("t1_idle", irq_req, 0);

        // lines 1 and 3 together
        IRQ = 4'b1010;
        tick(3);
        chk("t2_pend", pending, 4'b1010);
        tick(1);
        chk("t2_req1", irq_req, 1);
        chk("t2_id1", irq_id, 1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("t2_ack1", irq_req, 0);
        chk("t2_pend1", pending, 4'b1000);
        tick(1);
        chk("t2_gap", irq_req, 0);
        tick(1);
        chk("t2_req3", irq_req, 1);
        chk("t2_id3", irq_id, 3);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("t2_ack3", irq_req, 0);
        chk("t2_pend0", pending, 0);
        IRQ = 4'h0;
        tick(4);
        chk("t2_quiet", irq_req, 0);

        // level line 0
        edge_mode = 4'b1110;
        IRQ = 4'b0001;
        tick(3);
        chk("t3_pend", pending, 4'b0001);
        tick(1);
        chk("t3_req", irq_req, 1);
        chk("t3_id", irq_id, 0);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("t3_ack", irq_req, 0);
        chk("t3_lvl_pend", pending, 4'b0001);
        tick(1);
        chk("t3_gap", irq_req, 0);
        IRQ = 4'h0;
        tick(1);
        chk("t3_rereq", irq_req, 1);
        chk("t3_reid", irq_id, 0);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("t3_ack2", irq_req, 0);
        tick(1);
        chk("t3_pend0", pending, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("t3_stay0", irq_req, 0);
        end
        edge_mode = 4'hF;

        // overflow on line 2
        IRQ = 4'b0100;
        tick(1);
        IRQ = 4'h0;
        tick(3);
        chk("t4_req", irq_req, 1);
        chk("t4_id", irq_id, 2);
        IRQ = 4'b0100;
        tick(1);
        IRQ = 4'h0;
        tick(2);
        chk("t4_ovf", overflow, 4'b0100);
        chk("t4_still", irq_req, 1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("t4_pend_clr", pending, 0);
        chk("t4_ovf_clr", overflow, 0);
        tick(2);
        chk("t4_quiet", irq_req, 0);

        // edge landing on the ACK edge of the same line
        IRQ = 4'b0100;
        tick(1);
        IRQ = 4'h0;
        tick(3);
        chk("t4b_req", irq_req, 1);
        IRQ = 4'b0100;
        tick(1);
        IRQ = 4'h0;
        tick(1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("t4b_pend", pending, 4'b0100);
        chk("t4b_ovf", overflow, 0);
        chk("t4b_req0", irq_req, 0);
        tick(2);
        chk("t4b_rereq", irq_req, 1);
        chk("t4b_id", irq_id, 2);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("t4b_done", pending, 0);
        tick(2);

        // CONFIGURED low suppresses everything
        CONFIGURED = 1'b0;
        for (int k = 0; k < 8; k++) begin
            IRQ = (k % 2 == 0) ? 4'hF : 4'h0;
            tick(1);
            chk("t5_req", irq_req, 0);
            chk("t5_pend", pending, 0);
            chk("t5_ovf", overflow, 0);
        end
        IRQ = 4'h0;
        tick(4);
        CONFIGURED = 1'b1;
        IRQ = 4'b0010;
        tick(1);
        IRQ = 4'h0;
        tick(3);
        chk("t5_req1", irq_req, 1);
        chk("t5_id1", irq_id, 1);
        CONFIGURED = 1'b0;
        tick(1);
        chk("t5_drop", irq_req, 0);
        chk("t5_drop_pend", pending, 0);
        CONFIGURED = 1'b1;
        tick(2);
        chk("t5_after", irq_req, 0);

        // mask while in flight
        IRQ = 4'b0001;
        tick(1);
        IRQ = 4'h0;
        tick(3);
        chk("t6_req", irq_req, 1);
        chk("t6_id", irq_id, 0);
        irq_mask = 4'b1110;
        tick(1);
        chk("t6_hold", irq_req, 1);
        chk("t6_hold_id", irq_id, 0);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        chk("t6_ack", irq_req, 0);
        IRQ = 4'b0001;
        tick(1);
        IRQ = 4'h0;
        tick(2);
        chk("t6_pend_m", pending, 4'b0001);
        tick(2);
        chk("t6_masked", irq_req, 0);
        irq_mask = 4'hF;
        tick(1);
        chk("t6_unmask", irq_req, 1);
        chk("t6_unmask_id", irq_id, 0);

        // async reset mid-REQ
        #2;
        RESETn = 1'b0;
        #1;
        chk("t7_req", irq_req, 0);
        chk("t7_id", irq_id, 0);
        chk("t7_pend", pending, 0);
        tick(1);
        RESETn = 1'b1;
        tick(2);
        chk("t7_after", irq_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_irq_ctrl.md
# cpu_irq_ctrl

Interrupt controller between fabric-generated IRQ lines and the CPU interrupt input. It synchronizes the fabric IRQs into the CPU clock domain and latches them as edge- or level-type pending bits. It applies a CPU-side mask and presents one prioritized request at a time over a req/ack handshake. All requests are suppressed until the fabric reports it is configured.

## Interface
Parameters:
- NUM_IRQ, 4, number of fabric IRQ lines (1..32)
- ID_W, $clog2(NUM_IRQ) with a minimum of 1, width of irq_id

Ports:
- UserCLK  input  1  CPU-side clock; all state is on the rising edge
- RESETn  input  1  asynchronous, active-low reset
- IRQ  input  NUM_IRQ  raw fabric interrupt lines; asynchronous to UserCLK
- CONFIGURED  input  1  fabric-configured flag; requests are allowed only while it is high
- edge_mode  input  NUM_IRQ  per line: 1 = rising-edge type, 0 = level type; treated as quasi-static
- irq_mask  input  NUM_IRQ  per line: 1 = enabled
- irq_req  output  1  request to the CPU
- irq_id  output  ID_W  index of the requested line; valid while irq_req is high
- irq_ack  input  1  CPU acknowledge of the current request
- pending  output  NUM_IRQ  raw pending bits, before the mask is applied
- overflow  output  NUM_IRQ  sticky per line: an edge arrived while that line was already pending

## Operation
- Synchronizer: two flops per line (s1, s2) plus a history flop s3. Edge-type event: s2 & ~s3.
- Pending, edge type:
  - Set on an edge event.
  - Cleared when the line is acknowledged (ACK commit).
  - If set and clear occur in the same cycle, set wins.
- Pending, level type: follows s2 every cycle; an ACK has no effect on it.
- Overflow: set when an edge event hits an already-set pending bit; cleared by an ACK of that line; sticky otherwise.
- CONFIGURED low:
  - All pending and overflow bits are held at 0.
  - Synchronizer flops keep running.
  - The FSM is forced to IDLE.
- Eligibility: pending & irq_mask, evaluated only while CONFIGURED is high. The lowest index has the highest priority.
- FSM states are IDLE, REQ and GAP.
  - IDLE: if any line is eligible, capture the winning index into irq_id and go to REQ.
  - REQ: irq_req = 1 and irq_id stays stable. Mask or pending changes do not retract or change the request. When irq_ack = 1 is sampled, commit the clear and go to GAP.
  - GAP: irq_req = 0 for exactly one cycle, then go to IDLE.
  - Any state: if CONFIGURED = 0, go to IDLE on the next edge.
- irq_ack outside REQ is ignored.

## Timing
- Reset values:
  - irq_req = 0, irq_id = 0.
  - pending = 0, overflow = 0.
  - s1 = s2 = s3 = 0.
  - FSM in IDLE.
- Latency, IRQ to request: IRQ is stable high before UserCLK edge n. Then s2 = 1 after edge n+1, pending = 1 after edge n+2, and irq_req/irq_id appear after edge n+3.
- ACK: with irq_ack high at edge m, pending clears and the FSM enters GAP after m. irq_req is low after m and during m+1. The next request can assert after edge m+2 at the earliest.
- Level line still high after its ACK: it re-requests after edge m+2.
- A same-cycle ACK and a new edge on the same line (edge type) leaves pending = 1 with overflow unchanged.
- CONFIGURED drops while in REQ: irq_req is low after the next edge, with no ACK required.
- Reset asserted mid-REQ: all outputs go to their reset values immediately (asynchronous).
- irq_req and irq_id come directly from flops, with no combinational path from inputs.

## Test plan
- Single edge IRQ[2] pulse (NUM_IRQ = 4, edge_mode = 4'hF, mask = 4'hF, CONFIGURED = 1) -> irq_req rises 3 edges after sampling with irq_id = 2; ACK clears pending[2] and irq_req drops for exactly one cycle.
- IRQ[1] and IRQ[3] rise in the same cycle -> request id 1 first; after ACK and GAP, request id 3; then pending = 0.
- Level line 0 held high (edge_mode = 0) -> ACK, one-cycle GAP, then re-request with id 0; after IRQ[0] falls and the final ACK, irq_req stays 0.
- Second edge on line 2 while pending[2] = 1 -> overflow[2] = 1; ACK of id 2 clears both pending[2] and overflow[2].
- CONFIGURED = 0 with IRQ = 4'hF toggling -> irq_req, pending and overflow stay 0; CONFIGURED dropped during REQ -> irq_req is 0 after the next edge.
- Mask line 0 with IRQ[0] pending and request in flight -> the current request completes; afterward no request for line 0 while masked, and id 0 is requested once the mask is restored. Also: RESETn pulsed low mid-REQ -> irq_req = 0 immediately.
